// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: mult/div latencies, the Tuse/Tnew time type,
// the mult/div busy state encoding and the operand hazard test.
package pipe_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Tuse / Tnew are small cycle counts carried down the pipe
    typedef logic [1:0] tnew_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } md_state_e;

    // One source operand against one producing stage
    function automatic logic src_hazard(
        input logic       use_src,
        input logic [4:0] src,
        input tnew_t      tuse,
        input logic       reg_write,
        input logic [4:0] wa,
        input tnew_t      tnew
    );
        return use_src && (src != 5'd0) && reg_write && (wa == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy sequencer: loads the operation latency on a start seen in
// IDLE, counts it down in BUSY and pulses Md_Done as the result lands.
module md_busy_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Md_Start_E,
    input  logic Md_Div_E,
    output logic Md_Busy,
    output logic Md_Done
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // Next state: starts are only honoured in IDLE, so a stray start in BUSY
    // can never reload the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Md_Start_E) begin
                    cnt_d   = Md_Div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // State register on the pipeline's negedge; reset also kills a pending done
    always_ff @(negedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign Md_Busy = (state_q == StBusy);
    assign Md_Done = done_q;

endmodule

// File: rtl/stall_ctrl.sv
// Hazard and mult/div stall controller for the five-stage pipeline, plus a
// saturating count of stalled cycles.
module stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [1:0]  Tuse_Rs_D,
    input  logic [1:0]  Tuse_Rt_D,
    input  logic        Use_Rs_D,
    input  logic        Use_Rt_D,
    input  logic [4:0]  Wa_E,
    input  logic [4:0]  Wa_M,
    input  logic        RegWrite_E,
    input  logic        RegWrite_M,
    input  logic [1:0]  Tnew_E,
    input  logic [1:0]  Tnew_M,
    input  logic        Md_Use_D,
    input  logic        Md_Start_E,
    input  logic        Md_Div_E,
    output logic        Stall,
    output logic        Md_Busy,
    output logic        Md_Done,
    output logic [31:0] Stall_Cnt
);

    logic        rs_haz, rt_haz, md_haz, stall;
    logic [31:0] stall_cnt_q;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .Clk        (Clk),
        .Reset      (Reset),
        .Md_Start_E (Md_Start_E),
        .Md_Div_E   (Md_Div_E),
        .Md_Busy    (Md_Busy),
        .Md_Done    (Md_Done)
    );

    // Zero-latency hazard detect; a start still in E counts as busy for HI/LO users
    always_comb begin
        rs_haz = src_hazard(Use_Rs_D, Rs_D, Tuse_Rs_D, RegWrite_E, Wa_E, Tnew_E)
              || src_hazard(Use_Rs_D, Rs_D, Tuse_Rs_D, RegWrite_M, Wa_M, Tnew_M);
        rt_haz = src_hazard(Use_Rt_D, Rt_D, Tuse_Rt_D, RegWrite_E, Wa_E, Tnew_E)
              || src_hazard(Use_Rt_D, Rt_D, Tuse_Rt_D, RegWrite_M, Wa_M, Tnew_M);
        md_haz = Md_Use_D && (Md_Start_E || Md_Busy);
        stall  = !Reset && (rs_haz || rt_haz || md_haz);
    end

    // Saturating stalled-cycle counter
    always_ff @(negedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign Stall     = stall;
    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl with a scoreboard of expected outputs.
module tb_stall_ctrl;

    logic        Clk = 1'b1;
    logic        Reset;
    logic [4:0]  Rs_D, Rt_D, Wa_E, Wa_M;
    logic [1:0]  Tuse_Rs_D, Tuse_Rt_D, Tnew_E, Tnew_M;
    logic        Use_Rs_D, Use_Rt_D, RegWrite_E, RegWrite_M;
    logic        Md_Use_D, Md_Start_E, Md_Div_E;
    logic        Stall, Md_Busy, Md_Done;
    logic [31:0] Stall_Cnt;

    stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Rs_D       (Rs_D),
        .Rt_D       (Rt_D),
        .Tuse_Rs_D  (Tuse_Rs_D),
        .Tuse_Rt_D  (Tuse_Rt_D),
        .Use_Rs_D   (Use_Rs_D),
        .Use_Rt_D   (Use_Rt_D),
        .Wa_E       (Wa_E),
        .Wa_M       (Wa_M),
        .RegWrite_E (RegWrite_E),
        .RegWrite_M (RegWrite_M),
        .Tnew_E     (Tnew_E),
        .Tnew_M     (Tnew_M),
        .Md_Use_D   (Md_Use_D),
        .Md_Start_E (Md_Start_E),
        .Md_Div_E   (Md_Div_E),
        .Stall      (Stall),
        .Md_Busy    (Md_Busy),
        .Md_Done    (Md_Done),
        .Stall_Cnt  (Stall_Cnt)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: kind 0 Stall, 1 Md_Busy, 2 Md_Done, 3 Stall_Cnt
    int          kind_q[$];
    string       name_q[$];
    logic [31:0] exp_q[$];

    // Reference model: remaining busy edges, done pulse, stall count
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_scnt = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input int kind, input string name, input logic [31:0] exp);
        kind_q.push_back(kind);
        name_q.push_back(name);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        int          k;
        string       n;
        logic [31:0] e;
        while (kind_q.size() > 0) begin
            k = kind_q.pop_front();
            n = name_q.pop_front();
            e = exp_q.pop_front();
            case (k)
                0:       check_val({n, "/stall"}, {31'd0, Stall}, e);
                1:       check_val({n, "/busy"}, {31'd0, Md_Busy}, e);
                2:       check_val({n, "/done"}, {31'd0, Md_Done}, e);
                default: check_val({n, "/stall_cnt"}, Stall_Cnt, e);
            endcase
        end
    endtask

    task automatic clear_inputs();
        Rs_D = '0; Rt_D = '0; Wa_E = '0; Wa_M = '0;
        Tuse_Rs_D = '0; Tuse_Rt_D = '0; Tnew_E = '0; Tnew_M = '0;
        Use_Rs_D = 1'b0; Use_Rt_D = 1'b0; RegWrite_E = 1'b0; RegWrite_M = 1'b0;
        Md_Use_D = 1'b0; Md_Start_E = 1'b0; Md_Div_E = 1'b0;
    endtask

    // One pipeline cycle: called 1 time unit after posedge with inputs set
    task automatic step(input logic exp_stall, input string name);
        #1;
        push_exp(0, name, {31'd0, exp_stall});
        drain();
        if (Reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_scnt = '0;
        end else begin
            m_done = (m_left == 1);
            if (m_left > 0) m_left--;
            else if (Md_Start_E) m_left = Md_Div_E ? 10 : 5;
            if (exp_stall && (m_scnt != 32'hFFFF_FFFF)) m_scnt++;
        end
        push_exp(1, name, {31'd0, (m_left > 0)});
        push_exp(2, name, {31'd0, m_done});
        push_exp(3, name, m_scnt);
        @(negedge Clk);
        #1;
        drain();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Reset masks a live hazard and a start
        Use_Rs_D = 1'b1; Rs_D = 5'd3; RegWrite_E = 1'b1; Wa_E = 5'd3; Tnew_E = 2'd1;
        Md_Start_E = 1'b1; Md_Use_D = 1'b1;
        step(1'b0, "reset_hold0");
        step(1'b0, "reset_hold1");
        Reset = 1'b0;
        clear_inputs();
        step(1'b0, "idle");

        // Rs against E
        Use_Rs_D = 1'b1; Rs_D = 5'd3; Tuse_Rs_D = 2'd0;
        RegWrite_E = 1'b1; Wa_E = 5'd3; Tnew_E = 2'd1;
        step(1'b1, "rs_e_tnew1");
        Tnew_E = 2'd0;
        step(1'b0, "rs_e_tnew0");
        Tnew_E = 2'd2; Tuse_Rs_D = 2'd1;
        step(1'b1, "rs_e_tuse1_tnew2");
        Tuse_Rs_D = 2'd2;
        step(1'b0, "rs_e_tuse2_tnew2");
        RegWrite_E = 1'b0; Tuse_Rs_D = 2'd0;
        step(1'b0, "rs_e_nowrite");
        clear_inputs();

        // Rt against M (lw)
        Use_Rt_D = 1'b1; Rt_D = 5'd5; Tuse_Rt_D = 2'd1;
        RegWrite_M = 1'b1; Wa_M = 5'd5; Tnew_M = 2'd1;
        step(1'b0, "rt_m_tuse1");
        Tuse_Rt_D = 2'd0;
        step(1'b1, "rt_m_tuse0");
        Wa_M = 5'd0; Rt_D = 5'd0;
        step(1'b0, "rt_m_reg0");
        Rt_D = 5'd5; Wa_M = 5'd5; Use_Rt_D = 1'b0;
        step(1'b0, "rt_m_unused");
        Use_Rt_D = 1'b1; Wa_M = 5'd6;
        step(1'b0, "rt_m_other_reg");
        clear_inputs();

        // E and M hazards together
        Use_Rs_D = 1'b1; Rs_D = 5'd7; Tuse_Rs_D = 2'd1;
        RegWrite_E = 1'b1; Wa_E = 5'd7; Tnew_E = 2'd2;
        Use_Rt_D = 1'b1; Rt_D = 5'd9; Tuse_Rt_D = 2'd0;
        RegWrite_M = 1'b1; Wa_M = 5'd9; Tnew_M = 2'd1;
        repeat (3) step(1'b1, "dual_haz");
        clear_inputs();
        step(1'b0, "dual_release");

        // mult with mfhi waiting in D: 1 start cycle + 5 busy cycles stalled
        Md_Start_E = 1'b1; Md_Div_E = 1'b0; Md_Use_D = 1'b1;
        step(1'b1, "mult_start");
        Md_Start_E = 1'b0;
        repeat (5) step(1'b1, "mfhi_wait");
        step(1'b0, "mfhi_go");
        Md_Use_D = 1'b0;
        step(1'b0, "mult_quiet");

        // A start during BUSY must not reload
        Md_Start_E = 1'b1;
        step(1'b0, "mult2_start");
        Md_Div_E = 1'b1;
        step(1'b0, "restart_ignored");
        Md_Start_E = 1'b0; Md_Div_E = 1'b0;
        repeat (5) step(1'b0, "mult2_run");

        // div aborted by reset on its 4th busy edge
        Md_Start_E = 1'b1; Md_Div_E = 1'b1;
        step(1'b0, "div_start");
        Md_Start_E = 1'b0; Md_Div_E = 1'b0;
        repeat (3) step(1'b0, "div_run");
        Reset = 1'b1;
        step(1'b0, "div_reset");
        Reset = 1'b0;
        repeat (2) step(1'b0, "div_after");

        // Saturation from 0xFFFFFFFE under a continuous stall
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_scnt = 32'hFFFF_FFFE;
        Use_Rs_D = 1'b1; Rs_D = 5'd12; Tuse_Rs_D = 2'd0;
        RegWrite_M = 1'b1; Wa_M = 5'd12; Tnew_M = 2'd2;
        repeat (3) step(1'b1, "sat");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard and multiply/divide sequencing controller for the five-stage pipeline. Compares D-stage operand demand (Tuse) against E/M-stage result readiness (Tnew), runs the busy counter for the mult/div unit, and drives one stall that holds the PC and F/D register while the D/E register inserts a bubble through its `Pause` input. It also keeps a saturating stall-cycle counter for performance checks.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `CNT_W`, default 4: busy counter width; must hold `DIV_CYCLES`.
- `Clk`, in, 1: pipeline clock; state updates on the negedge, as the pipeline registers do.
- `Reset`, in, 1: reset Reset, synchronous, active-high.
- `Rs_D`, `Rt_D`, in, 5: D-stage source register numbers.
- `Tuse_Rs_D`, `Tuse_Rt_D`, in, 2: cycles until each operand is consumed.
- `Use_Rs_D`, `Use_Rt_D`, in, 1: the operand is actually read.
- `Wa_E`, `Wa_M`, in, 5: destination register in E and in M.
- `RegWrite_E`, `RegWrite_M`, in, 1: the stage writes the GRF.
- `Tnew_E`, `Tnew_M`, in, 2: stage Tnew, already decremented by the pipeline registers.
- `Md_Use_D`, in, 1: D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `Md_Start_E`, in, 1: E instruction is mult/multu/div/divu.
- `Md_Div_E`, in, 1: the E start is a divide.
- `Stall`, out, 1: holds the PC and F/D register; drives `Pause` of the D/E register.
- `Md_Busy`, out, 1: the mult/div unit is computing.
- `Md_Done`, out, 1: one-cycle pulse when HI/LO become valid.
- `Stall_Cnt`, out, 32: saturating count of stalled cycles.

## Operation
- Rs hazard: `Use_Rs_D`, `Rs_D != 0`, and either
  - `RegWrite_E` with `Wa_E == Rs_D` and `Tuse_Rs_D < Tnew_E`, or
  - `RegWrite_M` with `Wa_M == Rs_D` and `Tuse_Rs_D < Tnew_M`.
- Rt hazard: the same rule using `Rt_D`, `Use_Rt_D` and `Tuse_Rt_D`.
- MD hazard: `Md_Use_D` and (`Md_Start_E` or `Md_Busy`).
- `Stall` is the OR of the three hazards. It is combinational and is forced to 0 while `Reset` is high.
- Busy state machine:
  - IDLE: on `Md_Start_E`, load the counter with `DIV_CYCLES` if `Md_Div_E`, else `MULT_CYCLES`, then go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter is 1, pulse `Md_Done` on the same edge and return to IDLE with count 0.
- `Md_Busy` is 1 exactly in BUSY. Because `Md_Use_D` stalls, a second start cannot arrive while busy. If one does, it is ignored, because the counter never reloads in BUSY.
- `Stall_Cnt` increments on each edge where `Stall` is 1 and holds at 0xFFFFFFFF.
- All comparisons are unsigned. Register 0 never creates a hazard.

## Timing
- Reset values: state IDLE, counter 0, `Md_Busy` 0, `Md_Done` 0, `Stall_Cnt` 0, `Stall` 0.
- Reset has priority over `Md_Start_E`. A reset during BUSY aborts the operation with no `Md_Done` pulse.
- `Stall` has zero latency: it is valid the same cycle its inputs are, before the next negedge.
- `Md_Busy` rises on the first negedge after `Md_Start_E` and stays high for N edges (N = 5 or 10). `Md_Done` is high for the cycle following the N-th busy edge. An mfhi held in D leaves D on the edge after `Md_Busy` falls.
- E and M hazards at the same time still produce a single `Stall`.
- A Tnew of 0 never stalls.

## Structure
- A shared package `pipe_pkg` holds `MULT_CYCLES` and `DIV_CYCLES` defaults, the 2-bit Tuse/Tnew type, and the IDLE/BUSY state encoding.
- One sub-module, `md_busy_cnt`: the IDLE/BUSY machine with its counter, `Md_Busy` and `Md_Done`.
- The top level holds the hazard comparators and `Stall_Cnt`.

## Test plan
- addu $3 in E (`Tnew_E` = 1), D = beq $3 (`Tuse_Rs_D` = 0) -> `Stall` = 1; with `Tnew_E` = 0 -> `Stall` = 0.
- lw $5 in M (`Tnew_M` = 1), D = addu using rt = $5 (`Tuse_Rt_D` = 1) -> `Stall` = 0. Same case with `Wa_M` = 0 and `Tuse` = 0 -> `Stall` = 0.
- `Md_Start_E` with `Md_Div_E` = 0 -> `Md_Busy` high for 5 edges. `Md_Done` pulses once; mfhi in D stalls for 6 cycles, then 0.
- div start -> 10 busy edges. Reset asserted at busy edge 4 -> `Md_Busy` = 0, no `Md_Done`, `Stall_Cnt` = 0.
- Continuous stall from `Stall_Cnt` = 0xFFFFFFFE -> value holds at 0xFFFFFFFF.
- E and M hazards asserted together for 3 cycles -> `Stall` = 1 each cycle, `Stall_Cnt` increases by exactly 3.
